// File: rtl/jtdsp16_rom_fetch.sv
// jtdsp16_rom_fetch: direct-mapped line cache between the ROM AAU fetch port and slow external program memory.
// Optional macro JTDSP16_ROM_PREFETCH_EN adds a PREF state that fetches line L+1 after each demand fill of line L.

module jtdsp16_rom_fetch #(
   parameter int LW = 2,
   parameter int LN = 4,
   parameter int AW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [15:0]   rom_addr,
   output logic [15:0]   rom_dout,
   output logic          rom_wait,
   input  logic          inv,
   output logic          ext_cs,
   output logic [AW-1:0] ext_addr,
   input  logic [15:0]   ext_data,
   input  logic          ext_ok
);

   localparam int TW  = 16 - LW - LN;
   localparam int NL  = 1 << LN;
   localparam int NW  = 1 << (LW + LN);
   localparam int NPW = 1 << LW;

`ifdef JTDSP16_ROM_PREFETCH_EN
   typedef enum logic [1:0] {IDLE, FILL, PREF} state_t;
`else
   typedef enum logic [1:0] {IDLE, FILL} state_t;
`endif

   logic [15:0]   data_mem [NW];
   logic [TW-1:0] tag_mem  [NL];

   state_t        state_q, state_d;
   logic [NL-1:0] valid_q, valid_d;
   logic [AW-1:0] base_q, base_d;
   logic [AW-1:0] ext_addr_q, ext_addr_d;
   logic [LW-1:0] cnt_q, cnt_d;
   logic          ext_cs_q, ext_cs_d;
   logic          abort_q, abort_d;

   logic [LW-1:0] word;
   logic [LN-1:0] line;
   logic [TW-1:0] tag;
   logic          hit;
   logic [LN-1:0] fill_line;
   logic [TW-1:0] fill_tag;
   logic          accept;
   logic          tag_we;

   assign word      = rom_addr[LW-1:0];
   assign line      = rom_addr[LW+LN-1:LW];
   assign tag       = rom_addr[15:LW+LN];
   assign hit       = valid_q[line] && (tag_mem[line] == tag);
   assign rom_dout  = data_mem[{line, word}];
   assign fill_line = base_q[LW+LN-1:LW];
   assign fill_tag  = base_q[LW+LN +: TW];
   // ext_ok only counts while a request is actually outstanding
   assign accept    = ext_cs_q && ext_ok;
   assign ext_cs    = ext_cs_q;
   assign ext_addr  = ext_addr_q;

`ifdef JTDSP16_ROM_PREFETCH_EN
   logic [AW-1:0] pbase;
   logic [LN-1:0] next_line;
   logic          next_hit;

   assign pbase     = base_q + AW'(NPW);
   assign next_line = pbase[LW+LN-1:LW];
   assign next_hit  = valid_q[next_line] && (tag_mem[next_line] == pbase[LW+LN +: TW]);
   // a prefetch only blocks the core when the demand address is not cached
   assign rom_wait  = !hit || (state_q == FILL);
`else
   assign rom_wait  = !hit || (state_q != IDLE);
`endif

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      base_d     = base_q;
      cnt_d      = cnt_q;
      ext_cs_d   = ext_cs_q;
      ext_addr_d = ext_addr_q;
      abort_d    = abort_q;
      tag_we     = 1'b0;
      case (state_q)
         IDLE: begin
            if (inv) begin
               valid_d = '0;
            end else if (!hit) begin
               state_d       = FILL;
               base_d        = AW'({rom_addr[15:LW], {LW{1'b0}}});
               cnt_d         = '0;
               valid_d[line] = 1'b0;
               ext_cs_d      = 1'b1;
               ext_addr_d    = AW'({rom_addr[15:LW], {LW{1'b0}}});
               abort_d       = 1'b0;
            end
         end
         default: begin
            if (inv) abort_d = 1'b1;
            if (accept) begin
               cnt_d      = cnt_q + LW'(1);
               ext_cs_d   = 1'b0;
               ext_addr_d = base_q + AW'(cnt_q) + AW'(1);
               if (abort_q || inv) begin
                  // the in-flight word is done; drop the line and flush everything
                  state_d = IDLE;
                  abort_d = 1'b0;
                  valid_d = '0;
               end else if (cnt_q == '1) begin
                  tag_we             = 1'b1;
                  valid_d[fill_line] = 1'b1;
                  state_d            = IDLE;
`ifdef JTDSP16_ROM_PREFETCH_EN
                  if (state_q == FILL && !next_hit) begin
                     state_d            = PREF;
                     base_d             = pbase;
                     cnt_d              = '0;
                     ext_addr_d         = pbase;
                     valid_d[next_line] = 1'b0;
                  end
`endif
               end
            end else if (!ext_cs_q) begin
               if (abort_q || inv) begin
                  state_d = IDLE;
                  abort_d = 1'b0;
                  valid_d = '0;
               end else begin
                  ext_cs_d = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         valid_q    <= '0;
         base_q     <= '0;
         cnt_q      <= '0;
         ext_cs_q   <= 1'b0;
         ext_addr_q <= '0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         base_q     <= base_d;
         cnt_q      <= cnt_d;
         ext_cs_q   <= ext_cs_d;
         ext_addr_q <= ext_addr_d;
         abort_q    <= abort_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) data_mem[{fill_line, cnt_q}] <= ext_data;
      if (tag_we) tag_mem[fill_line] <= fill_tag;
   end

endmodule

// File: tb/tb_jtdsp16_rom_fetch.sv
// Bench for jtdsp16_rom_fetch: external memory returns addr^A5A5 after LAT cycles; a cache-content model predicts hit/miss and request lists.

module tb_jtdsp16_rom_fetch;

   localparam int LAT = 2;
   localparam int TMO = 300;
`ifdef JTDSP16_ROM_PREFETCH_EN
   localparam bit PF = 1'b1;
`else
   localparam bit PF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] rom_addr = '0;
   logic [15:0] rom_dout;
   logic        rom_wait;
   logic        inv = 1'b0;
   logic        ext_cs;
   logic [15:0] ext_addr;
   logic [15:0] ext_data = '0;
   logic        ext_ok = 1'b0;

   int n_checks = 0;
   int n_err = 0;

   jtdsp16_rom_fetch dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rom_addr (rom_addr),
      .rom_dout (rom_dout),
      .rom_wait (rom_wait),
      .inv      (inv),
      .ext_cs   (ext_cs),
      .ext_addr (ext_addr),
      .ext_data (ext_data),
      .ext_ok   (ext_ok)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // External memory: answers every request with addr^A5A5 after LAT cycles of ext_cs.
   bit          resp_en = 1'b1;
   int          rcnt = 0;
   logic [15:0] req_log[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         ext_ok = 1'b0;
         rcnt = 0;
      end else if (resp_en) begin
         if (ext_ok) begin
            ext_ok = 1'b0;
            rcnt = 0;
         end else if (ext_cs) begin
            rcnt++;
            if (rcnt >= LAT) begin
               ext_ok = 1'b1;
               ext_data = ext_addr ^ 16'hA5A5;
               req_log.push_back(ext_addr);
            end
         end else begin
            rcnt = 0;
         end
      end
   end

   // Continuous compare: any word delivered must equal memory content; ext_addr held while waiting.
   logic        prev_cs = 1'b0;
   logic        prev_ok = 1'b0;
   logic [15:0] prev_addr = '0;

   always @(negedge clk) begin
      #2;
      if (rst_n) begin
         if (rom_wait === 1'b0) begin
            chk("dout_vs_mem", rom_dout, rom_addr ^ 16'hA5A5);
            if (!PF) chk("cs_while_ready", ext_cs, 1'b0);
         end
         if (ext_cs && prev_cs && !prev_ok) chk("ext_addr_stable", ext_addr, prev_addr);
      end
      prev_cs = ext_cs;
      prev_ok = ext_ok;
      prev_addr = ext_addr;
   end

   // Cache-content model: which tag each line holds, if any.
   bit         mvalid[16];
   logic [9:0] mtag[16];

   function automatic bit m_hit(input logic [15:0] a);
      return mvalid[a[5:2]] && (mtag[a[5:2]] == a[15:6]);
   endfunction

   function automatic void m_clear();
      for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
   endfunction

   // Records a demand fill of a's line; returns how many external words it costs.
   function automatic int m_fill(input logic [15:0] a);
      logic [15:0] b;
      bit          pref;
      b = (a & 16'hFFFC) + 16'd4;
      mvalid[a[5:2]] = 1'b1;
      mtag[a[5:2]] = a[15:6];
      pref = PF && !m_hit(b);
      if (pref) begin
         mvalid[b[5:2]] = 1'b1;
         mtag[b[5:2]] = b[15:6];
      end
      return pref ? 8 : 4;
   endfunction

   task automatic settle();
      int quiet = 0;
      int n = 0;
      while (quiet < 4 && n < TMO) begin
         @(negedge clk); #1;
         n++;
         quiet = ext_cs ? 0 : quiet + 1;
      end
      chk("settle_timeout", (quiet >= 4), 1'b1);
   endtask

   task automatic wait_ready(input string nm);
      int n = 0;
      while (rom_wait !== 1'b0 && n < TMO) begin
         @(negedge clk); #1;
         n++;
      end
      chk(nm, (n < TMO), 1'b1);
   endtask

   task automatic fetch(input logic [15:0] a, input bit lit_miss);
      bit          mm;
      int          w;
      int          nreq;
      logic [15:0] base;
      base = a & 16'hFFFC;
      mm = !m_hit(a);
      chk("model_vs_literal_miss", mm, lit_miss);
      @(negedge clk);
      inv = 1'b0;
      req_log.delete();
      rom_addr = a;
      #1;
      w = 0;
      while (rom_wait !== 1'b0 && w < TMO) begin
         @(negedge clk); #1;
         w++;
      end
      // entry cycle + 4 words x (LAT + gap), minus the final gap in which the hit is already visible
      chk("wait_cycles", w, mm ? 4 * (LAT + 1) : 0);
      chk("fetch_dout", rom_dout, a ^ 16'hA5A5);
      nreq = 0;
      if (mm) begin
         nreq = m_fill(a);
         settle();
      end
      chk("req_count", req_log.size(), nreq);
      for (int i = 0; i < nreq && i < req_log.size(); i++)
         chk("req_addr", req_log[i], 16'(base + 16'(i)));
      $display("fetch addr=%h miss=%0d wait=%0d reqs=%0d dout=%h", a, mm, w, req_log.size(), rom_dout);
   endtask

   initial begin
      int n;
      int exp_n;
      logic [15:0] exp_inv[7];

      m_clear();
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ext_cs", ext_cs, 1'b0);
      chk("rst_ext_addr", ext_addr, 16'h0000);
      chk("rst_rom_wait", rom_wait, 1'b1);
      $display("reset: ext_cs=%b ext_addr=%h rom_wait=%b", ext_cs, ext_addr, rom_wait);

      // release with inv held: inv wins over the miss, so no fill may start yet
      @(negedge clk);
      rst_n = 1'b1;
      inv = 1'b1;

      // 1-2: first fill, then sequential fetch over two lines
      fetch(16'h0000, 1'b1);
      chk("lit_dout_0", rom_dout, 16'hA5A5);
      for (int i = 1; i < 8; i++) fetch(16'(i), (i == 4) && !PF);

      // 3: same line, different tags
      fetch(16'h0010, 1'b1);
      chk("lit_dout_10", rom_dout, 16'hA5B5);
      fetch(16'h0050, 1'b1);
      chk("lit_dout_50", rom_dout, 16'hA5F5);
      fetch(16'h0010, 1'b1);
      fetch(16'h0013, 1'b0);

      // 4: inv while word 2 is outstanding
      @(negedge clk);
      req_log.delete();
      rom_addr = 16'h0020;
      #1;
      n = 0;
      while (!(ext_cs === 1'b1 && ext_addr == 16'h0022) && n < TMO) begin
         @(negedge clk); #1;
         n++;
      end
      chk("inv_word2_seen", (n < TMO), 1'b1);
      inv = 1'b1;
      @(negedge clk);
      inv = 1'b0;
      wait_ready("inv_refill_timeout");
      chk("inv_refill_dout", rom_dout, 16'h0020 ^ 16'hA5A5);
      settle();
      m_clear();
      exp_n = 3 + m_fill(16'h0020);
      exp_inv = '{16'h0020, 16'h0021, 16'h0022, 16'h0020, 16'h0021, 16'h0022, 16'h0023};
      chk("inv_req_count", req_log.size(), exp_n);
      for (int i = 0; i < 7 && i < req_log.size(); i++) chk("inv_req_addr", req_log[i], exp_inv[i]);
      $display("inv mid-fill: reqs=%0d dout=%h", req_log.size(), rom_dout);

      // inv in IDLE: still a hit this cycle, all lines gone the next
      @(negedge clk);
      req_log.delete();
      inv = 1'b1;
      #1;
      chk("inv_idle_same_cycle", rom_wait, 1'b0);
      @(negedge clk);
      inv = 1'b0;
      #1;
      chk("inv_idle_next_cycle", rom_wait, 1'b1);
      wait_ready("inv_idle_refill_timeout");
      settle();
      m_clear();
      exp_n = m_fill(16'h0020);
      chk("inv_idle_req_count", req_log.size(), exp_n);
      $display("inv idle: reqs=%0d dout=%h", req_log.size(), rom_dout);
      fetch(16'h0000, 1'b1);

      // 5: top-of-memory line, then reset in the middle of a fill
      fetch(16'hFFFE, 1'b1);
      chk("lit_dout_fffe", rom_dout, 16'h5A5B);
      @(negedge clk);
      req_log.delete();
      rom_addr = 16'h0030;
      n = 0;
      while (req_log.size() < 2 && n < TMO) begin
         @(negedge clk);
         n++;
      end
      chk("rst_mid_fill_progress", (n < TMO), 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_fill_cs", ext_cs, 1'b0);
      chk("rst_mid_fill_wait", rom_wait, 1'b1);
      m_clear();
      $display("reset mid-fill: ext_cs=%b rom_wait=%b", ext_cs, rom_wait);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      inv = 1'b1;
      resp_en = 1'b0;
      #1;
      ext_ok = 1'b1;
      ext_data = 16'hDEAD;
      @(posedge clk);
      #1;
      ext_ok = 1'b0;
      resp_en = 1'b1;
      fetch(16'h0030, 1'b1);
      fetch(16'h0033, 1'b0);

      // 6: next-line prefetch
      fetch(16'h0100, 1'b1);
      fetch(16'h0104, !PF);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
